// File: rtl/xmem_addr_gen.sv
// ============================================================================
//  Module      : xmem_addr_gen
//  Description : Two-level (nested-loop) address generator for one port of a
//                dual-port data memory. It streams a strided 2-D address
//                pattern with a registered enable, and needs no processor
//                involvement once the pass has started.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   clock
//    rst_n       in   synchronous reset, active low
//    run         in   start pulse; accepted only in IDLE or DONE
//    stall       in   freeze counters and outputs while high
//    start       in   first address
//    iterations  in   outer loop count (number of periods)
//    period      in   inner loop length in cycles
//    duty        in   enabled cycles at the start of each period
//    delay       in   idle cycles between run and the first period
//    incr        in   two's-complement step after each enabled cycle
//    shift       in   two's-complement step at the end of each period
//    addr        out  registered memory address
//    en          out  registered memory port enable
//    busy        out  high in DELAY and RUN
//    done        out  high in DONE until the next accepted run
// ============================================================================
`default_nettype none

module xmem_addr_gen #(
  parameter int DADDR_W  = 11,
  parameter int PERIOD_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                stall,
  input  logic [DADDR_W-1:0]  start,
  input  logic [DADDR_W-1:0]  iterations,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] duty,
  input  logic [PERIOD_W-1:0] delay,
  input  logic [DADDR_W-1:0]  incr,
  input  logic [DADDR_W-1:0]  shift,
  output logic [DADDR_W-1:0]  addr,
  output logic                en,
  output logic                busy,
  output logic                done
);

  localparam logic [PERIOD_W-1:0] c_ONE_P = PERIOD_W'(1);
  localparam logic [DADDR_W-1:0]  c_ONE_A = DADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;

  // Configuration captured when a run is accepted and held for the pass.
  logic [DADDR_W-1:0]  r_start;
  logic [DADDR_W-1:0]  r_iter;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_duty;
  logic [DADDR_W-1:0]  r_incr;
  logic [DADDR_W-1:0]  r_shift;

  // Loop counters. r_pcnt/r_icnt describe the cycle currently on the outputs.
  logic [PERIOD_W-1:0] r_dcnt;
  logic [PERIOD_W-1:0] r_pcnt;
  logic [DADDR_W-1:0]  r_icnt;

  logic                w_last_p;
  logic                w_last_i;
  logic [PERIOD_W-1:0] w_pnext;
  logic [DADDR_W-1:0]  w_step;

  assign w_last_p = (r_pcnt == (r_period - c_ONE_P));
  assign w_last_i = (r_icnt == (r_iter - c_ONE_A));
  assign w_pnext  = r_pcnt + c_ONE_P;
  // Both steps apply when the last cycle of a period is also an enabled one.
  assign w_step   = (en ? r_incr : '0) + (w_last_p ? r_shift : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_start  <= '0;
      r_iter   <= '0;
      r_period <= '0;
      r_duty   <= '0;
      r_incr   <= '0;
      r_shift  <= '0;
      r_dcnt   <= '0;
      r_pcnt   <= '0;
      r_icnt   <= '0;
      addr     <= '0;
      en       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (!stall) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (run) begin
            r_start  <= start;
            r_iter   <= iterations;
            r_period <= period;
            r_duty   <= duty;
            r_incr   <= incr;
            r_shift  <= shift;
            r_dcnt   <= delay;
            r_pcnt   <= '0;
            r_icnt   <= '0;
            en       <= 1'b0;
            if ((iterations == '0) || (period == '0)) begin
              // Empty pass: report completion without ever enabling the port.
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (delay != '0) begin
              r_state <= S_DELAY;
              addr    <= start;
              busy    <= 1'b1;
              done    <= 1'b0;
            end else begin
              r_state <= S_RUN;
              addr    <= start;
              en      <= (duty != '0);
              busy    <= 1'b1;
              done    <= 1'b0;
            end
          end
        end

        S_DELAY: begin
          // r_dcnt reaches 1 on the edge that closes the last delay cycle.
          if (r_dcnt == c_ONE_P) begin
            r_state <= S_RUN;
            addr    <= r_start;
            en      <= (r_duty != '0);
          end
          r_dcnt <= r_dcnt - c_ONE_P;
        end

        S_RUN: begin
          if (w_last_p && w_last_i) begin
            // Address holds the last value issued.
            r_state <= S_DONE;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            addr <= addr + w_step;
            if (w_last_p) begin
              r_pcnt <= '0;
              r_icnt <= r_icnt + c_ONE_A;
              en     <= (r_duty != '0);
            end else begin
              r_pcnt <= w_pnext;
              en     <= (w_pnext < r_duty);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
